// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core and its boot-time program loader.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_MAGIC,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into XLEN-bit words and emits a one-cycle
// word_valid pulse in the cycle after the last byte of each word arrives.
module word_assembler #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            last_lane,
    output logic            word_valid,
    output logic [XLEN-1:0] word_data
);

    logic [1:0]      lane;
    logic [XLEN-9:0] buffer;

    assign last_lane = (lane == 2'd3);

    // The final byte bypasses the buffer so the buffer can take the next word's first byte immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane       <= 2'd0;
            buffer     <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                lane <= lane + 2'd1;
                if (last_lane) begin
                    word_data  <= {byte_data, buffer};
                    word_valid <= 1'b1;
                end else begin
                    buffer[{lane, 3'b000} +: 8] <= byte_data;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed, checksummed program image and writes it into
// instruction memory, holding the core in reset until the image is verified.
module imem_loader #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

    import riscv_pkg::*;

    loader_state_t     state, state_next;
    logic              ready_st;
    logic              accept;
    logic              data_byte;
    logic [7:0]        len_lo;
    logic [7:0]        csum;
    logic [15:0]       word_count;
    logic [15:0]       words_rcvd;
    logic [16:0]       len_full;
    logic [ADDR_W-1:0] waddr;
    logic              last_lane;
    logic              word_valid;
    logic [XLEN-1:0]   word_data;

    assign len_full  = {1'b0, rx_data, len_lo};
    assign rx_ready  = ready_st && !reset;
    assign accept    = rx_valid && rx_ready;
    assign data_byte = accept && (state == DATA);

    word_assembler #(.XLEN(XLEN)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (data_byte),
        .byte_data  (rx_data),
        .last_lane  (last_lane),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_next = state;
        ready_st   = 1'b0;
        case (state)
            WAIT_MAGIC: begin
                ready_st = 1'b1;
                if (rx_valid && rx_data == LOADER_MAGIC) state_next = LEN_LO;
            end
            LEN_LO: begin
                ready_st = 1'b1;
                if (rx_valid) state_next = LEN_HI;
            end
            LEN_HI: begin
                ready_st = 1'b1;
                if (rx_valid) begin
                    if (len_full > 17'(IMEM_DEPTH)) state_next = ERROR;
                    else if (len_full == 17'd0)     state_next = CHECK;
                    else                            state_next = DATA;
                end
            end
            DATA: begin
                ready_st = 1'b1;
                // Leave on the last payload byte; its word write lands while we sit in CHECK.
                if (rx_valid && last_lane && words_rcvd == word_count - 16'd1) state_next = CHECK;
            end
            CHECK: begin
                ready_st = 1'b1;
                if (rx_valid) state_next = (rx_data == csum) ? DONE : ERROR;
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = WAIT_MAGIC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_MAGIC;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            state      <= state_next;
            load_done  <= (state_next == DONE);
            load_error <= (state_next == ERROR);
            core_reset <= (state_next != DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo     <= '0;
            word_count <= '0;
            words_rcvd <= '0;
            waddr      <= '0;
            csum       <= '0;
        end else begin
            if (accept && state == LEN_LO) len_lo <= rx_data;
            if (accept && state == LEN_HI) word_count <= {rx_data, len_lo};
            if (data_byte) begin
                csum <= csum ^ rx_data;
                if (last_lane) words_rcvd <= words_rcvd + 16'd1;
            end
            if (word_valid) waddr <= waddr + 1'b1;
        end
    end

    // A write pending when reset arrives must not reach imem.
    assign imem_we    = word_valid && !reset;
    assign imem_waddr = waddr;
    assign imem_wdata = word_data;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader against a frame/word reference model.
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          load_done;
    logic          load_error;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] payload[$];
    int          capAddr[$];
    logic [31:0] capData[$];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    // Record every write strobe, sampled mid-cycle.
    always begin
        @(negedge clk);
        #1;
        if (imem_we === 1'b1) begin
            capAddr.push_back(int'(imem_waddr));
            capData.push_back(imem_wdata);
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        checkOutput("rst_rx_ready",   32'(rx_ready),   32'd0);
        checkOutput("rst_imem_we",    32'(imem_we),    32'd0);
        checkOutput("rst_waddr",      32'(imem_waddr), 32'd0);
        checkOutput("rst_wdata",      imem_wdata,      32'd0);
        checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
        checkOutput("rst_load_done",  32'(load_done),  32'd0);
        checkOutput("rst_load_error", 32'(load_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        capAddr.delete();
        capData.delete();
    endtask

    // Offer one byte, optionally with random idle cycles, until it is accepted.
    task automatic sendByte(input logic [7:0] b, input bit bubbles);
        bit done   = 1'b0;
        int waited = 0;
        while (!done) begin
            rx_data  = b;
            rx_valid = (bubbles && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            #1;
            if (rx_valid && rx_ready) done = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            if (!done) begin
                waited++;
                if (waited > 100) begin
                    checkOutput("accept_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
    endtask

    // Build a frame from payload[0..n-1], send it, and check against the frame rules.
    task automatic applyStimulus(input int garbage, input int n, input bit corrupt, input bit bubbles);
        logic [7:0]  frame[$];
        logic [7:0]  cs = 8'h00;
        logic [7:0]  g;
        logic [31:0] w;
        bit          expErr;
        int          expWrites;
        int          nCmp;
        for (int i = 0; i < garbage; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            frame.push_back(g);
        end
        frame.push_back(8'hA5);
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                w = payload[i];
                for (int k = 0; k < 4; k++) begin
                    frame.push_back(w[8*k +: 8]);
                    cs = cs ^ w[8*k +: 8];
                end
            end
            frame.push_back(corrupt ? (cs ^ (8'h01 << $urandom_range(0, 7))) : cs);
        end
        expErr    = (n > DEPTH) || corrupt;
        expWrites = (n <= DEPTH) ? n : 0;

        for (int i = 0; i < frame.size() - 1; i++) sendByte(frame[i], bubbles);
        checkOutput("done_before_last", 32'(load_done), 32'd0);
        sendByte(frame[frame.size() - 1], bubbles);
        checkOutput("done_timing",  32'(load_done),  32'(!expErr));
        checkOutput("error_timing", 32'(load_error), 32'(expErr));

        repeat (4) @(negedge clk);
        #2;
        checkOutput("write_count", 32'(capAddr.size()), 32'(expWrites));
        nCmp = (capAddr.size() < expWrites) ? capAddr.size() : expWrites;
        for (int i = 0; i < nCmp; i++) begin
            checkOutput("waddr", 32'(capAddr[i]), 32'(i));
            checkOutput("wdata", capData[i], payload[i]);
        end
        checkOutput("final_done",       32'(load_done),  32'(!expErr));
        checkOutput("final_error",      32'(load_error), 32'(expErr));
        checkOutput("final_core_reset", 32'(core_reset), 32'(expErr));
        checkOutput("final_rx_ready",   32'(rx_ready),   32'd0);
    endtask

    task automatic loadNominal();
        payload.delete();
        payload.push_back(32'h00500093);
        payload.push_back(32'h00300113);
        payload.push_back(32'h002081B3);
    endtask

    // Abort a nominal frame with reset after nBytes payload bytes, then replay it.
    task automatic resetMidFrame(input int nBytes);
        logic [31:0] w;
        loadNominal();
        doReset();
        sendByte(8'hA5, 1'b0);
        sendByte(8'h03, 1'b0);
        sendByte(8'h00, 1'b0);
        for (int i = 0; i < nBytes; i++) begin
            w = payload[i / 4];
            sendByte(w[8*(i % 4) +: 8], 1'b0);
        end
        reset = 1'b1;
        #1;
        checkOutput("we_during_reset", 32'(imem_we), 32'd0);
        #2;
        checkOutput("partial_writes", 32'(capAddr.size()), 32'((nBytes - 1) / 4));
        doReset();
        applyStimulus(0, 3, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int r;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        loadNominal();
        doReset();
        applyStimulus(0, 3, 1'b0, 1'b0);
        doReset();
        applyStimulus(0, 3, 1'b1, 1'b0);
        doReset();
        applyStimulus(3, 3, 1'b0, 1'b0);
        doReset();
        applyStimulus(0, 3, 1'b0, 1'b1);

        doReset();
        applyStimulus(0, 257, 1'b0, 1'b0);
        doReset();
        applyStimulus(0, 0, 1'b0, 1'b0);

        resetMidFrame(6);
        resetMidFrame(4);

        payload.delete();
        for (int i = 0; i < DEPTH; i++) payload.push_back($urandom);
        doReset();
        applyStimulus(1, DEPTH, 1'b0, 1'b0);

        for (int it = 0; it < 16; it++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       n = r;
            else if (r == 7) n = DEPTH;
            else             n = 257 + $urandom_range(0, 60000);
            payload.delete();
            for (int i = 0; i < DEPTH; i++) payload.push_back($urandom);
            doReset();
            applyStimulus($urandom_range(0, 3), n, ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
